// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 responder.
//   DATA_W_DEF      : default bits per SPI frame
//   SYNC_STAGES_DEF : default synchroniser depth for the asynchronous SPI inputs
//   IDLE_TX_DEF     : default byte shifted out when no tx byte is pending
//   state_t         : responder FSM encoding
package spi_pkg;

    localparam int         DATA_W_DEF      = 8;
    localparam int         SYNC_STAGES_DEF = 2;
    localparam logic [7:0] IDLE_TX_DEF     = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for one asynchronous SPI input plus edge detection.
//   clk   in  system clock
//   reset in  asynchronous active-low reset; chain presets to RESET_VAL
//   din   in  asynchronous input
//   sync  out synchronised level (last chain stage)
//   rise  out one-clk pulse when the synchronised level goes 0 -> 1
//   fall  out one-clk pulse when the synchronised level goes 1 -> 0
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_r;
    logic                   dly_r;

    // synchroniser chain plus one extra stage holding the previous synchronised level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_r <= {SYNC_STAGES{RESET_VAL}};
            dly_r   <= RESET_VAL;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], din};
            dly_r   <= chain_r[SYNC_STAGES-1];
        end
    end

    assign sync = chain_r[SYNC_STAGES-1];
    assign rise = chain_r[SYNC_STAGES-1] & ~dly_r;
    assign fall = ~chain_r[SYNC_STAGES-1] & dly_r;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first), oversampled on clk.
//   clk, reset          system clock, asynchronous active-low reset
//   sclk, mosi, sce, dc SPI bus from the master (asynchronous to clk)
//   miso                serial data back to the master
//   tx_data, tx_load    byte for the next frame and its write strobe
//   tx_ready            tx buffer empty
//   rx_data, rx_dc      last received byte and its dc tag
//   rx_valid, rx_ack    rx holding register full / consumer acknowledge
//   overrun             sticky: unacknowledged byte was overwritten
//   frame_err           one-clk pulse: sce rose in the middle of a byte
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [DATA_W-1:0] IDLE_TX   = DATA_W'(IDLE_TX_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              sce,
    input  logic              dc,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_dc,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              overrun,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise_s, sclk_fall_s, mosi_s, dc_s, sce_rise_s, sce_fall_s;
    logic unused_sclk_lvl_s, unused_sce_lvl_s;
    logic unused_mosi_rise_s, unused_mosi_fall_s, unused_dc_rise_s, unused_dc_fall_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .sync(unused_sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .sync(mosi_s), .rise(unused_mosi_rise_s), .fall(unused_mosi_fall_s)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sce (
        .clk(clk), .reset(reset), .din(sce),
        .sync(unused_sce_lvl_s), .rise(sce_rise_s), .fall(sce_fall_s)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
        .clk(clk), .reset(reset), .din(dc),
        .sync(dc_s), .rise(unused_dc_rise_s), .fall(unused_dc_fall_s)
    );

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_W-1:0]   shift_rx_r, shift_rx_nxt_s;
    logic [DATA_W-1:0]   shift_tx_r, shift_tx_nxt_s;
    logic [DATA_W-1:0]   tx_buf_r, tx_buf_nxt_s;
    logic [DATA_W-1:0]   rx_data_r, rx_data_nxt_s;
    logic                miso_r, miso_nxt_s;
    logic                tx_ready_r, tx_ready_nxt_s;
    logic                rx_dc_r, rx_dc_nxt_s;
    logic                rx_valid_r, rx_valid_nxt_s;
    logic                overrun_r, overrun_nxt_s;
    logic                frame_err_r, frame_err_nxt_s;
    logic                tx_take_s, byte_done_s;
    logic [DATA_W-1:0]   pending_s, rx_byte_s;

    // next-state logic: FSM, bit counter, shift registers, tx buffer and rx handshake
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_rx_nxt_s  = shift_rx_r;
        shift_tx_nxt_s  = shift_tx_r;
        tx_buf_nxt_s    = tx_buf_r;
        rx_data_nxt_s   = rx_data_r;
        miso_nxt_s      = miso_r;
        tx_ready_nxt_s  = tx_ready_r;
        rx_dc_nxt_s     = rx_dc_r;
        rx_valid_nxt_s  = rx_valid_r;
        overrun_nxt_s   = overrun_r;
        frame_err_nxt_s = 1'b0;
        byte_done_s     = 1'b0;
        rx_byte_s       = {shift_rx_r[DATA_W-2:0], mosi_s};
        tx_take_s       = tx_load & tx_ready_r;

        // a load in the same cycle as a reload goes straight into the shifter
        if (tx_take_s) begin
            pending_s = tx_data;
        end else if (!tx_ready_r) begin
            pending_s = tx_buf_r;
        end else begin
            pending_s = IDLE_TX;
        end

        if (tx_take_s) begin
            tx_buf_nxt_s   = tx_data;
            tx_ready_nxt_s = 1'b0;
        end else begin
            tx_buf_nxt_s   = tx_buf_r;
        end

        case (state_r)
            ST_IDLE: begin
                miso_nxt_s = 1'b0;
                if (sce_fall_s) begin
                    state_nxt_s    = ST_SHIFT;
                    bit_cnt_nxt_s  = CNT_ZERO;
                    shift_tx_nxt_s = pending_s;
                    tx_ready_nxt_s = 1'b1;
                    miso_nxt_s     = pending_s[DATA_W-1];
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sce_rise_s) begin
                    state_nxt_s     = ST_IDLE;
                    miso_nxt_s      = 1'b0;
                    bit_cnt_nxt_s   = CNT_ZERO;
                    frame_err_nxt_s = (bit_cnt_r != CNT_ZERO);
                end else if (sclk_rise_s) begin
                    shift_rx_nxt_s = rx_byte_s;
                    if (bit_cnt_r == LAST_BIT) begin
                        byte_done_s    = 1'b1;
                        bit_cnt_nxt_s  = CNT_ZERO;
                        shift_tx_nxt_s = pending_s;
                        tx_ready_nxt_s = 1'b1;
                    end else begin
                        bit_cnt_nxt_s  = bit_cnt_r + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    // after a byte boundary the freshly reloaded MSB is presented unshifted
                    if (bit_cnt_r == CNT_ZERO) begin
                        miso_nxt_s     = shift_tx_r[DATA_W-1];
                    end else begin
                        shift_tx_nxt_s = {shift_tx_r[DATA_W-2:0], 1'b0};
                        miso_nxt_s     = shift_tx_r[DATA_W-2];
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                miso_nxt_s  = 1'b0;
            end
        endcase

        // a new byte wins over a simultaneous acknowledge
        if (byte_done_s) begin
            rx_data_nxt_s  = rx_byte_s;
            rx_dc_nxt_s    = dc_s;
            rx_valid_nxt_s = 1'b1;
            overrun_nxt_s  = overrun_r | (rx_valid_r & ~rx_ack);
        end else if (rx_ack) begin
            rx_valid_nxt_s = 1'b0;
            overrun_nxt_s  = 1'b0;
        end else begin
            rx_valid_nxt_s = rx_valid_r;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= CNT_ZERO;
            shift_rx_r  <= {DATA_W{1'b0}};
            shift_tx_r  <= {DATA_W{1'b0}};
            tx_buf_r    <= {DATA_W{1'b0}};
            rx_data_r   <= {DATA_W{1'b0}};
            miso_r      <= 1'b0;
            tx_ready_r  <= 1'b1;
            rx_dc_r     <= 1'b0;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_rx_r  <= shift_rx_nxt_s;
            shift_tx_r  <= shift_tx_nxt_s;
            tx_buf_r    <= tx_buf_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            miso_r      <= miso_nxt_s;
            tx_ready_r  <= tx_ready_nxt_s;
            rx_dc_r     <= rx_dc_nxt_s;
            rx_valid_r  <= rx_valid_nxt_s;
            overrun_r   <= overrun_nxt_s;
            frame_err_r <= frame_err_nxt_s;
        end
    end

    assign miso      = miso_r;
    assign tx_ready  = tx_ready_r;
    assign rx_data   = rx_data_r;
    assign rx_dc     = rx_dc_r;
    assign rx_valid  = rx_valid_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: a behavioural SPI master (4 clk per sclk phase)
// plus a byte-level reference model of the rx/tx handshakes.
module tb_spi_slave_rx;

    localparam int         HALF     = 4;
    localparam logic [7:0] IDLE_EXP = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclk = 1'b0, mosi = 1'b0, sce = 1'b1, dc = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, overrun, frame_err;
    logic       rx_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_pulses = 0, fe_high = 0;
    logic fe_prev = 1'b0;
    int fe_p0, fe_h0;

    // reference model state
    logic [7:0] m_rx_data = 8'h00;
    logic       m_rx_dc = 1'b0, m_valid = 1'b0, m_over = 1'b0;
    logic       m_pend_v = 1'b0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] exp_out = 8'h00;

    always #5 clk = ~clk;

    spi_slave_rx dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .overrun(overrun), .frame_err(frame_err)
    );

    // frame_err pulse and high-cycle counters
    always @(negedge clk) begin
        fe_pulses <= fe_pulses + ((frame_err && !fe_prev) ? 1 : 0);
        fe_high   <= fe_high + (frame_err ? 1 : 0);
        fe_prev   <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_dc", 32'(rx_dc), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    // next byte the responder will shift out: pending tx byte or the idle byte
    task automatic m_reload(output logic [7:0] o);
        o = m_pend_v ? m_pend : IDLE_EXP;
        m_pend_v = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (!m_pend_v) begin
            m_pend   = b;
            m_pend_v = 1'b1;
        end
        check("tx_ready_after_load", 32'(tx_ready), 32'(!m_pend_v));
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        check("ack_rx_valid", 32'(rx_valid), 32'd0);
        check("ack_overrun", 32'(overrun), 32'd0);
    endtask

    task automatic frame_start();
        sce = 1'b0;
        m_reload(exp_out);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        sce = 1'b1;
        repeat (HALF + 2) @(negedge clk);
    endtask

    // master shifts nbits of b (MSB first); act 1/2 = rx_ack / tx_load on the final-rise cycle
    task automatic xfer(input logic [7:0] b, input logic d, input int nbits, input int act,
                        input logic [7:0] act_b, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = b[i];
            dc   = d;
            repeat (HALF) @(negedge clk);
            got[i] = miso;
            sclk = 1'b1;
            if (i == 0 && act != 0) begin
                repeat (2) @(negedge clk);
                if (act == 1) begin
                    rx_ack = 1'b1;
                end else begin
                    tx_data = act_b;
                    tx_load = 1'b1;
                end
                @(negedge clk);
                rx_ack  = 1'b0;
                tx_load = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic d, input int act, input logic [7:0] act_b);
        logic [7:0] got, want;
        want = exp_out;
        xfer(b, d, 8, act, act_b, got);
        check("miso_byte", 32'(got), 32'(want));
        if (act != 1 && m_valid) m_over = 1'b1;
        m_valid   = 1'b1;
        m_rx_data = b;
        m_rx_dc   = d;
        if (act == 2 && !m_pend_v) exp_out = act_b;
        else m_reload(exp_out);
        check("rx_data", 32'(rx_data), 32'(m_rx_data));
        check("rx_dc", 32'(rx_dc), 32'(m_rx_dc));
        check("rx_valid", 32'(rx_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_over));
        check("tx_ready", 32'(tx_ready), 32'(!m_pend_v));
    endtask

    initial begin
        logic [7:0] dummy;
        int nb;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        fe_p0 = fe_pulses; fe_h0 = fe_high;

        // 1: single byte 0xA5 with dc=1
        frame_start();
        send(8'hA5, 1'b1, 0, 8'h00);
        frame_end();
        check("t1_no_frame_err", 32'(fe_pulses - fe_p0), 32'd0);
        check("t1_rx_valid_held", 32'(rx_valid), 32'd1);
        do_ack();

        // 2: tx byte 0x3C returned; second load while full is ignored
        do_load(8'h3C);
        do_load(8'h99);
        frame_start();
        send(8'h00, 1'b0, 0, 8'h00);
        frame_end();
        do_ack();

        // 3: back-to-back bytes without ack -> overrun
        frame_start();
        send(8'h21, 1'b0, 0, 8'h00);
        send(8'h0C, 1'b1, 0, 8'h00);
        frame_end();
        check("t3_overrun", 32'(overrun), 32'd1);
        do_ack();

        // 4: sce raised after 5 rises -> one-cycle frame_err, then clean byte 0x80
        fe_p0 = fe_pulses; fe_h0 = fe_high;
        frame_start();
        xfer(8'hE7, 1'b1, 5, 0, 8'h00, dummy);
        frame_end();
        check("t4_fe_pulses", 32'(fe_pulses - fe_p0), 32'd1);
        check("t4_fe_width", 32'(fe_high - fe_h0), 32'd1);
        check("t4_rx_valid", 32'(rx_valid), 32'd0);
        frame_start();
        send(8'h80, 1'b0, 0, 8'h00);
        frame_end();

        // 5: final rise of 0x55 coincides with ack of 0x80
        frame_start();
        send(8'h55, 1'b1, 1, 8'h00);
        frame_end();

        // tx_load on the byte-boundary reload cycle goes straight out
        frame_start();
        send(8'h12, 1'b1, 2, 8'h6B);
        send(8'h34, 1'b0, 0, 8'h00);
        frame_end();
        do_ack();

        // 6: reset pulse mid-byte, then a clean 0xFF frame
        frame_start();
        send(8'hC3, 1'b1, 0, 8'h00);
        do_load(8'h5A);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        @(negedge clk);
        sclk = 1'b0;
        frame_end();
        m_rx_data = 8'h00; m_rx_dc = 1'b0; m_valid = 1'b0; m_over = 1'b0; m_pend_v = 1'b0;
        frame_start();
        send(8'hFF, 1'b1, 0, 8'h00);
        frame_end();
        do_ack();

        // randomized frames against the model
        fe_p0 = fe_pulses;
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
            nb = $urandom_range(1, 3);
            frame_start();
            for (int k = 0; k < nb; k++) send(8'($urandom), 1'($urandom), 0, 8'h00);
            frame_end();
            if ($urandom_range(0, 1) == 1) do_ack();
        end
        check("rand_no_frame_err", 32'(fe_pulses - fe_p0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
